// File: rtl/crypt_pkg.sv
// Shared types and defaults for the crypt datapath stages.
package crypt_pkg;

  typedef enum logic [1:0] {
    OP_INV   = 2'b00,
    OP_ROR   = 2'b01,
    OP_ROL   = 2'b10,
    OP_INVLO = 2'b11
  } op_e;

  localparam int unsigned DefLanes = 4;
  localparam int unsigned DefLaneW = 8;

endpackage

// File: rtl/stage1_lane_xform.sv
// Combinational single-lane stage-1 transform: invert, rotate or low-half invert,
// with rotate direction swapped in decrypt mode.
module stage1_lane_xform
  import crypt_pkg::*;
#(
  parameter int unsigned LANE_W = DefLaneW,
  parameter int unsigned ROT    = 2
) (
  input  logic [LANE_W-1:0] lane_i,
  input  logic [1:0]        key_i,
  input  logic              decrypt_i,
  output logic [LANE_W-1:0] lane_o
);

  if ((LANE_W % 2) != 0 || LANE_W < 4) begin : g_bad_lane_w
    $error("stage1_lane_xform: LANE_W must be even and >= 4");
  end
  if (ROT < 1 || ROT > LANE_W - 1) begin : g_bad_rot
    $error("stage1_lane_xform: ROT must be in 1..LANE_W-1");
  end

  localparam logic [LANE_W-1:0] LoMask = {{(LANE_W/2){1'b0}}, {(LANE_W/2){1'b1}}};

  logic [LANE_W-1:0] ror, rol;
  op_e               op;

  assign ror = (lane_i >> ROT) | (lane_i << (LANE_W - ROT));
  assign rol = (lane_i << ROT) | (lane_i >> (LANE_W - ROT));
  assign op  = op_e'(key_i);

  always_comb begin
    lane_o = lane_i;
    unique case (op)
      OP_INV:   lane_o = ~lane_i;
      OP_ROR:   lane_o = decrypt_i ? rol : ror;
      OP_ROL:   lane_o = decrypt_i ? ror : rol;
      OP_INVLO: lane_o = lane_i ^ LoMask;
      default:  lane_o = lane_i;
    endcase
  end

endmodule

// File: rtl/stage1_xform_pipe.sv
// Stage-1 lane transform with valid/ready handshake, one-entry skid buffer,
// key pass-through and completed-block counter.
module stage1_xform_pipe
  import crypt_pkg::*;
#(
  parameter int unsigned LANES  = DefLanes,
  parameter int unsigned LANE_W = DefLaneW,
  parameter int unsigned ROT    = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [1:0]              in_key,
  input  logic                    in_decrypt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [1:0]              out_key,
  output logic [CNT_W-1:0]        blk_count
);

  localparam int unsigned DataW = LANES * LANE_W;

  logic [DataW-1:0] xf_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    stage1_lane_xform #(
      .LANE_W (LANE_W),
      .ROT    (ROT)
    ) u_xform (
      .lane_i    (in_data[i*LANE_W +: LANE_W]),
      .key_i     (in_key),
      .decrypt_i (in_decrypt),
      .lane_o    (xf_data[i*LANE_W +: LANE_W])
    );
  end

  logic             out_valid_q, out_valid_d;
  logic [DataW-1:0] out_data_q, out_data_d;
  logic [1:0]       out_key_q, out_key_d;
  logic             skid_valid_q, skid_valid_d;
  logic [DataW-1:0] skid_data_q, skid_data_d;
  logic [1:0]       skid_key_q, skid_key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept, drain;

  assign accept = in_valid & ~skid_valid_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_key_d    = out_key_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_key_d   = skid_key_q;
    cnt_d        = cnt_q + CNT_W'(drain);

    if (drain) begin
      // A full skid entry blocks accept, so it is the only candidate to refill.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_key_d    = skid_key_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d = xf_data;
        out_key_d  = in_key;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (!out_valid_q) begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = xf_data;
        out_key_d   = in_key;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = xf_data;
      skid_key_d   = in_key;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_key_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_key_q   <= '0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_key_q    <= out_key_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_key_q   <= skid_key_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_key   = out_key_q;
  assign blk_count = cnt_q;

endmodule
